// File: rtl/onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter_if
//   Bus bundle for one master port of onchip_mem_arbiter. One instance per
//   master; the arbiter connects to the slave modport.
//
//   address        12  word address
//   byteenable      4  byte lanes used by writes
//   read / write    1  transfer request (write wins if both are set)
//   lock            1  owner asks to keep the grant for consecutive transfers
//   writedata      32  write data
//   waitrequest     1  request not accepted this cycle
//   readdata       32  read data, zero unless readdatavalid
//   readdatavalid   1  readdata valid this cycle
// ---------------------------------------------------------------------------
interface onchip_mem_arbiter_if;
    logic [11:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic        lock;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, byteenable, read, write, lock, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, lock, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//   Two-master arbiter in front of a single-port synchronous RAM. At most one
//   transfer is accepted per cycle; the winner's address/byteenable/writedata
//   drive the RAM combinationally. Read data returns one cycle after
//   acceptance to the master recorded in a one-bit tag.
//
//   Parameters
//     LOCK_MAX   1..255  consecutive locked grants while the other master waits
//     RR_ENABLE  1 = round-robin ties, 0 = fixed priority (m0 wins ties)
//
//   Ports
//     clk             sole clock, rising edge
//     reset           synchronous, active-high
//     m0, m1          master buses (onchip_mem_arbiter_if.slave)
//     ram_chipselect  high only in a cycle with an accepted transfer
//     ram_write       high only for an accepted write
//     ram_address     RAM word address
//     ram_byteenable  RAM byte lanes
//     ram_writedata   RAM write data
//     ram_readdata    RAM q, valid one cycle after the read address
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int unsigned LOCK_MAX  = 8,
    parameter bit          RR_ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    onchip_mem_arbiter_if.slave  m0,
    onchip_mem_arbiter_if.slave  m1,
    output logic                 ram_chipselect,
    output logic                 ram_write,
    output logic [11:0]          ram_address,
    output logic [3:0]           ram_byteenable,
    output logic [31:0]          ram_writedata,
    input  logic [31:0]          ram_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    state_t      state, next_state;
    logic [7:0]  lock_cnt, lock_cnt_next;
    logic        last_served;   // 0 = m0, 1 = m1
    logic        rd_pending;    // a read was accepted last cycle
    logic        rd_tag;        // destination master of that read

    logic        req0, req1;
    logic        gnt_valid;
    logic        gnt_sel;       // 0 = m0, 1 = m1
    logic        gnt_write;
    logic        gnt_lock;
    logic        gnt_is_owner;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Grant selection and next-state logic.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        gnt_valid     = 1'b0;
        gnt_sel       = 1'b0;
        next_state    = IDLE;
        lock_cnt_next = 8'd0;

        if (!reset && (req0 || req1)) begin
            gnt_valid = 1'b1;

            // Plain arbitration: the sole requester, or the tie-break rule.
            if (req0 && req1) begin
                gnt_sel = RR_ENABLE ? ~last_served : 1'b0;
            end else begin
                gnt_sel = req1;
            end

            // A locked owner keeps the grant until it has used LOCK_MAX
            // transfers while the other master is waiting; then the grant is
            // forced across, even under fixed priority.
            if (state == OWN0 && m0.lock && req0) begin
                gnt_sel = (lock_cnt < LOCK_LIMIT || !req1) ? 1'b0 : 1'b1;
            end else if (state == OWN1 && m1.lock && req1) begin
                gnt_sel = (lock_cnt < LOCK_LIMIT || !req0) ? 1'b1 : 1'b0;
            end

            next_state = gnt_sel ? OWN1 : OWN0;

            // Count only consecutive locked transfers by the same owner; a new
            // owner that arrives locked starts at one.
            if (gnt_lock) begin
                if (!gnt_is_owner) begin
                    lock_cnt_next = 8'd1;
                end else if (lock_cnt >= LOCK_LIMIT) begin
                    lock_cnt_next = LOCK_LIMIT;
                end else begin
                    lock_cnt_next = lock_cnt + 8'd1;
                end
            end
        end
    end

    assign gnt_write    = gnt_sel ? m1.write : m0.write;
    assign gnt_lock     = gnt_sel ? m1.lock  : m0.lock;
    assign gnt_is_owner = gnt_sel ? (state == OWN1) : (state == OWN0);

    // RAM port: driven by the winner in the same cycle.
    assign ram_chipselect = gnt_valid;
    assign ram_write      = gnt_valid & gnt_write;
    assign ram_address    = gnt_sel ? m1.address    : m0.address;
    assign ram_byteenable = gnt_sel ? m1.byteenable : m0.byteenable;
    assign ram_writedata  = gnt_sel ? m1.writedata  : m0.writedata;

    assign m0.waitrequest = req0 & ~(gnt_valid & ~gnt_sel);
    assign m1.waitrequest = req1 & ~(gnt_valid &  gnt_sel);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lock_cnt    <= 8'd0;
            last_served <= 1'b1;
            rd_pending  <= 1'b0;
            rd_tag      <= 1'b0;
        end else begin
            state      <= next_state;
            lock_cnt   <= lock_cnt_next;
            rd_pending <= gnt_valid & ~gnt_write;
            rd_tag     <= gnt_sel;
            if (gnt_valid) begin
                last_served <= gnt_sel;
            end
        end
    end

    // Read return. Gated by reset so a read accepted just before reset
    // asserts never reaches its master.
    assign m0.readdatavalid = rd_pending & ~reset & ~rd_tag;
    assign m1.readdatavalid = rd_pending & ~reset &  rd_tag;
    assign m0.readdata      = m0.readdatavalid ? ram_readdata : 32'h0;
    assign m1.readdata      = m1.readdatavalid ? ram_readdata : 32'h0;

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 8, max consecutive granted transfers for a locked owner while the other master waits (range 1..255).
REQ-002 Parameter RR_ENABLE, default 1: 1 = round-robin, 0 = fixed priority with m0 highest.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mN_address  in  12  word address, N in {0,1}.
REQ-006 mN_byteenable  in  4  byte lanes for writes.
REQ-007 mN_read / mN_write  in  1 each  transfer request.
REQ-008 mN_lock  in  1  owner requests to keep the grant across consecutive transfers.
REQ-009 mN_writedata  in  32  write data.
REQ-010 mN_waitrequest  out  1  request not accepted this cycle.
REQ-011 mN_readdata  out  32  read data.
REQ-012 mN_readdatavalid  out  1  mN_readdata valid this cycle.
REQ-013 ram_chipselect, ram_write  out  1 each  single-port RAM controls.
REQ-014 ram_address  out  12 / ram_byteenable  out  4 / ram_writedata  out  32  RAM port.
REQ-015 ram_readdata  in  32  RAM q, valid one cycle after the read address is presented.

Function
REQ-016 One transfer is accepted per cycle at most; the accepted master's address, byteenable and writedata drive the RAM port combinationally in the same cycle.
REQ-017 Request = mN_read | mN_write; with both asserted the transfer is a write and the read is dropped.
REQ-018 mN_waitrequest = request & ~accepted, combinational; it is 0 when the master is idle.
REQ-019 Grant state: IDLE, OWN0, OWN1; IDLE -> OWNn when master n wins; OWNn -> OWNn while mn_lock=1 and the lock count is below LOCK_MAX or the other master is idle; OWNn -> winner of a new arbitration otherwise; any state -> IDLE when no request.
REQ-020 Arbitration with RR_ENABLE=1: the master not served last wins a tie; the last_served pointer updates on every accepted transfer.
REQ-021 Arbitration with RR_ENABLE=0: m0 wins every tie, lock rules unchanged.
REQ-022 The 8-bit lock counter increments per accepted transfer by a locked owner, clears on owner change or when mN_lock drops, and saturates at LOCK_MAX.
REQ-023 When the lock counter equals LOCK_MAX and the other master is requesting, the grant is forced to the other master on the next accepted transfer.
REQ-024 ram_chipselect = 1 only in a cycle with an accepted transfer; ram_write = 1 only for an accepted write; otherwise ram_address, ram_byteenable and ram_writedata are don't-care.
REQ-025 Read latency: for a read accepted in cycle T, mN_readdatavalid = 1 in cycle T+1 only, with mN_readdata = ram_readdata; a registered tag selects the destination master.
REQ-026 Back-to-back reads from either master are accepted every cycle; return data stays in order, one beat per cycle.
REQ-027 Writes produce no readdatavalid; a read after a write to the same address returns the new data.
REQ-028 mN_readdata for the non-selected master is held at 0.

Reset
REQ-029 While reset=1: both waitrequest outputs equal their request, readdatavalid = 0, ram_chipselect = 0, ram_write = 0, state IDLE, lock counter 0, last_served = m1 so m0 wins the first tie.
REQ-030 A read accepted in the cycle reset asserts produces no readdatavalid; no transfer is accepted in any reset cycle.

Verification
REQ-031 After reset, m0 writes 0xDEADBEEF to addr 0x010 with byteenable 0xF, then reads it -> readdatavalid one cycle after acceptance, m0_readdata = 0xDEADBEEF.
REQ-032 Both masters read every cycle, no lock, RR_ENABLE=1 -> grants alternate m0, m1, m0, ...; each master sees waitrequest = 1 on alternate cycles; data returns in order.
REQ-033 m1 writes with byteenable 0x3, data 0x0000ABCD, over 0xDEADBEEF at 0x010 -> a later read returns 0xDEADABCD.
REQ-034 LOCK_MAX=4; m0 holds lock and requests continuously, m1 requests -> m0 gets 4 consecutive grants, then m1 is granted.
REQ-035 RR_ENABLE=0, both masters request continuously, no lock -> m0 is always granted, m1 waitrequest stays 1.
REQ-036 Assert reset the cycle after a read is accepted -> no readdatavalid; after release the first tie goes to m0.
